regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Two-requester write-back arbiter that sequences EXU and LSU results into the register file's single valid/ready write port. It sits between the execute/load-store units and the register file: accepts one result per grant, holds it stable until the register file handshakes, and exports a pending-write mask so decode can stall on in-flight destinations. Fairness is round-robin, and the register-file PC update travels with each write.

## Interface
- ADDR_WIDTH, 5: register address width; only bits [3:0] are significant (16 architectural registers).
- DATA_WIDTH, 32: write data width.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- exu_valid / lsu_valid  in  1  requester has a result.
- exu_ready / lsu_ready  out  1  arbiter accepts this cycle (combinational); reset value 0.
- exu_waddr / lsu_waddr  in  ADDR_WIDTH  destination register.
- exu_wdata / lsu_wdata  in  DATA_WIDTH  result data.
- exu_wen / lsu_wen  in  1  write enable; 0 means PC-only commit.
- exu_next_pc / lsu_next_pc  in  32  PC to commit with this result.
- rf_valid  out  1  write request to register file; reset 0.
- rf_ready  in  1  register file ready.
- rf_waddr, rf_wdata, rf_wen, rf_next_pc  out  ADDR_WIDTH/DATA_WIDTH/1/32  latched payload; reset 0.
- pending_mask  out  16  bit i set while a write to x[i] is accepted but not yet in the register file; reset 0.
- perf_commit_cnt, perf_conflict_cnt  out  32  performance counters (see Configuration); reset 0.

## Operation
- States: IDLE, HOLD. Reset → IDLE, prio = EXU, payload and pending_mask cleared.
- IDLE: ready asserted to exactly one requester, chosen combinationally: only one valid → that one; both valid → requester named by prio. Neither valid → both ready 0.
- Accept = valid && ready: latch waddr/wdata/wen/next_pc, record grant id, go to HOLD.
- HOLD: both requester readies 0; rf_valid = 1; payload outputs constant. On rf_valid && rf_ready: go to IDLE, set prio to the requester not just served.
- prio changes only on a completed rf handshake, never on accept.
- pending_mask: on accept with wen=1 and waddr[3:0]≠0, set bit waddr[3:0]. One cycle after the rf handshake, clear that bit (register file writes in the cycle after handshake). Writes to x0 or wen=0 never touch the mask.
- Simultaneous set and clear of the same bit in one edge: set wins.
- rf_ready while rf_valid=0 is ignored. Requester valid may drop without acceptance; no state change.
- Reset in HOLD: payload discarded, no rf handshake issued, mask cleared, prio = EXU.

## Timing
- Accept in cycle T → rf_valid in T+1. If rf_ready is high in T+1, the register file commits at the end of T+2, and the pending bit clears from T+3.
- Peak throughput: one write per 2 cycles, matching the register file's IDLE/WRITE rhythm.
- No combinational path from rf_ready to exu_ready/lsu_ready. The only combinational paths are requester valid and state to ready.
- rf_* outputs driven only from registers.

## Configuration
- WB_ARB_PERF_EN defined:
  - perf_commit_cnt increments on every rf handshake.
  - perf_conflict_cnt increments every IDLE cycle with both valids high.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by reset.
- Not defined: both counter outputs are tied to 0 and no counter flops exist. Ports remain in both builds.

## Structure
- Shared package regfile_wb_pkg holds:
  - state typedef (IDLE, HOLD);
  - requester id constants (REQ_EXU=0, REQ_LSU=1);
  - NUM_ARCH_REGS=16.
- One sub-module, wb_rr_arb2: 2-way round-robin grant logic (valids, prio → one-hot grant). Registering prio stays in the parent.

## Test plan
- EXU only, waddr=5, wdata=0xDEADBEEF, wen=1, next_pc=0x30000004, rf_ready=1 → exu_ready at T, rf_valid at T+1 with that payload, pending_mask=0x0020 during T+1..T+2, 0 at T+3.
- Both valid continuously after reset → grants EXU, LSU, EXU, LSU; perf_conflict_cnt counts every IDLE cycle (PERF_EN build).
- rf_ready held 0 for 4 cycles in HOLD → rf_* stable, both requester readies 0, prio unchanged; released on fifth cycle → back to IDLE next cycle.
- LSU write to x0 with wen=1, then EXU with wen=0 → pending_mask stays 0; both commit PCs reach rf_next_pc.
- Back-to-back writes to x3: second accepted in the cycle the first's bit clears → bit remains 1 until second write commits.
- Reset asserted in HOLD → next cycle rf_valid=0, pending_mask=0, counters=0, and the first grant after release goes to EXU when both are valid.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and constants for the write-back arbiter
// Purpose: FSM state type, requester ids and architectural register count
//          used by regfile_wb_arbiter and wb_rr_arb2.
// Ports:   none (package).
package regfile_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wb_state_e;

    localparam int REQ_EXU       = 0;
    localparam int REQ_LSU       = 1;
    localparam int NUM_ARCH_REGS = 16;

    // One-hot bit for an architectural register index.
    function automatic logic [NUM_ARCH_REGS-1:0] reg_onehot(input logic [3:0] idx);
        return NUM_ARCH_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// rtl/wb_rr_arb2.sv - 2-way round-robin grant logic
// Purpose: picks one requester from two valids; on conflict the requester
//          named by prio_i wins. Purely combinational; prio is registered
//          by the parent.
// Ports:   valid_i[1:0] requester valids (bit REQ_EXU / REQ_LSU)
//          prio_i       id of the requester preferred on conflict
//          grant_o[1:0] one-hot grant, zero when no valid
module wb_rr_arb2
    import regfile_wb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o          = 2'b00;
        grant_o[REQ_EXU] = valid_i[REQ_EXU] && (!valid_i[REQ_LSU] || (prio_i == 1'(REQ_EXU)));
        grant_o[REQ_LSU] = valid_i[REQ_LSU] && (!valid_i[REQ_EXU] || (prio_i == 1'(REQ_LSU)));
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - EXU/LSU write-back arbiter onto the register file port
// Purpose: accepts one result per grant from EXU or LSU (round-robin on
//          conflict), holds it on the rf_* valid/ready port until the register
//          file takes it, and tracks in-flight destinations in pending_mask.
// Ports:   clock, reset            clock and synchronous active-high reset
//          exu_* / lsu_*           requester valid/ready + waddr/wdata/wen/next_pc
//          rf_valid, rf_ready      register-file write handshake
//          rf_waddr/wdata/wen/next_pc  registered payload
//          pending_mask            destinations accepted but not yet written
//          perf_commit_cnt, perf_conflict_cnt  counters, live only when
//                                  WB_ARB_PERF_EN is defined, else tied to 0
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     exu_valid,
    output logic                     exu_ready,
    input  logic [ADDR_WIDTH-1:0]    exu_waddr,
    input  logic [DATA_WIDTH-1:0]    exu_wdata,
    input  logic                     exu_wen,
    input  logic [31:0]              exu_next_pc,

    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_waddr,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata,
    input  logic                     lsu_wen,
    input  logic [31:0]              lsu_next_pc,

    output logic                     rf_valid,
    input  logic                     rf_ready,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic                     rf_wen,
    output logic [31:0]              rf_next_pc,

    output logic [NUM_ARCH_REGS-1:0] pending_mask,
    output logic [31:0]              perf_commit_cnt,
    output logic [31:0]              perf_conflict_cnt
);

    wb_state_e state_q, state_d;
    logic      prio_q, prio_d;
    logic      gnt_id_q;

    logic [ADDR_WIDTH-1:0]    waddr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     wen_q;
    logic [31:0]              pc_q;
    logic [NUM_ARCH_REGS-1:0] mask_q, mask_d;

    // Clear of the served destination is delayed one cycle: the register
    // file writes in the cycle after the handshake.
    logic       clr_vld_q;
    logic [3:0] clr_idx_q;

    logic [1:0]            grant;
    logic                  accept;
    logic                  rf_hs;
    logic                  sel_exu;
    logic [ADDR_WIDTH-1:0] sel_waddr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wen;
    logic [31:0]           sel_pc;
    logic [NUM_ARCH_REGS-1:0] set_vec, clr_vec;

    wb_rr_arb2 u_arb (
        .valid_i ({lsu_valid, exu_valid}),
        .prio_i  (prio_q),
        .grant_o (grant)
    );

    // Readies depend only on requester valids and registered state.
    assign accept = (state_q == IDLE) && (grant != 2'b00);
    assign rf_hs  = (state_q == HOLD) && rf_ready;

    assign sel_exu   = grant[REQ_EXU];
    assign sel_waddr = sel_exu ? exu_waddr   : lsu_waddr;
    assign sel_wdata = sel_exu ? exu_wdata   : lsu_wdata;
    assign sel_wen   = sel_exu ? exu_wen     : lsu_wen;
    assign sel_pc    = sel_exu ? exu_next_pc : lsu_next_pc;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'(REQ_EXU);
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state logic; prio only moves on a completed rf handshake.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rf_ready) begin
                    state_d = IDLE;
                    prio_d  = (gnt_id_q == 1'(REQ_EXU)) ? 1'(REQ_LSU) : 1'(REQ_EXU);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        rf_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                exu_ready = grant[REQ_EXU];
                lsu_ready = grant[REQ_LSU];
            end
            HOLD: rf_valid = 1'b1;
            default: ;
        endcase
    end

    // Payload capture on accept; held constant through HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_id_q <= 1'(REQ_EXU);
            waddr_q  <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            pc_q     <= '0;
        end else if (accept) begin
            gnt_id_q <= sel_exu ? 1'(REQ_EXU) : 1'(REQ_LSU);
            waddr_q  <= sel_waddr;
            wdata_q  <= sel_wdata;
            wen_q    <= sel_wen;
            pc_q     <= sel_pc;
        end
    end

    // Pending destinations. x0 and PC-only commits never mark a bit; a set
    // in the same edge as a clear of that bit wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accept && sel_wen && (sel_waddr[3:0] != 4'd0)) begin
            set_vec = reg_onehot(sel_waddr[3:0]);
        end
        if (clr_vld_q) begin
            clr_vec = reg_onehot(clr_idx_q);
        end
        mask_d = (mask_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q    <= '0;
            clr_vld_q <= 1'b0;
            clr_idx_q <= 4'd0;
        end else begin
            mask_q    <= mask_d;
            clr_vld_q <= rf_hs && wen_q && (waddr_q[3:0] != 4'd0);
            clr_idx_q <= waddr_q[3:0];
        end
    end

    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign rf_wen       = wen_q;
    assign rf_next_pc   = pc_q;
    assign pending_mask = mask_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] commit_cnt_q;
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            commit_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (rf_hs) begin
                commit_cnt_q <= commit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && exu_valid && lsu_valid) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_commit_cnt   = commit_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`else
    assign perf_commit_cnt   = 32'd0;
    assign perf_conflict_cnt = 32'd0;
`endif

endmodule
